// File: rtl/uart_tx.sv
// 8N1 UART transmitter: byte FIFO on a valid/ready port, LSB-first serialiser.
// TXD is registered so the pin never glitches between bit periods.
module uart_tx #(
  parameter int CLK_FREQ_HZ = 12_000_000,
  parameter int BAUD_RATE   = 115_200,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                          CLK,
  input  logic                          RESET,
  input  logic [7:0]                    wr_data,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  output logic                          TXD,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   level
);

  localparam int DIV = CLK_FREQ_HZ / BAUD_RATE;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int LW  = AW + 1;
  localparam int CW  = $clog2(DIV);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [2:0]    bit_idx, bit_idx_d;
  logic [7:0]    shift, shift_d;
  logic          txd_d;
  logic          bit_end;
  logic          push, pop, full;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;

  // Space is judged from registered occupancy only, so a pop never frees a slot in its own cycle.
  assign full     = (level == LW'(FIFO_DEPTH));
  assign wr_ready = !full && !RESET;
  assign push     = wr_valid && wr_ready;
  assign busy     = (state != IDLE) || (level != '0);

  always_comb begin
    state_d   = state;
    cnt_d     = cnt + CW'(1);
    bit_idx_d = bit_idx;
    shift_d   = shift;
    pop       = 1'b0;
    bit_end   = (cnt == CW'(DIV - 1));
    case (state)
      IDLE: begin
        cnt_d = '0;
        if (level != '0) begin
          pop     = 1'b1;
          shift_d = mem[rd_ptr];
          state_d = START;
        end
      end
      START: begin
        if (bit_end) begin
          state_d   = DATA;
          cnt_d     = '0;
          bit_idx_d = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_d = '0;
          if (bit_idx == 3'd7) begin
            state_d = STOP;
          end else begin
            shift_d   = {1'b0, shift[7:1]};
            bit_idx_d = bit_idx + 3'd1;
          end
        end
      end
      STOP: begin
        // Chaining straight into the next start bit keeps frames gap-free.
        if (bit_end) begin
          cnt_d = '0;
          if (level != '0) begin
            pop     = 1'b1;
            shift_d = mem[rd_ptr];
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    case (state_d)
      START:   txd_d = 1'b0;
      DATA:    txd_d = shift_d[0];
      default: txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
      TXD     <= 1'b1;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      bit_idx <= bit_idx_d;
      shift   <= shift_d;
      TXD     <= txd_d;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: directed pushes, scoreboard of expected bytes checked by a
// line decoder, plus cycle-exact timing checks on a DIV=4 and a DIV=3 instance.
module tb_uart_tx;

  localparam int DIV_A = 4;

  logic       CLK   = 1'b0;
  logic       RESET = 1'b0;
  logic [7:0] wr_data  = '0;
  logic       wr_valid = 1'b0;
  logic       wr_ready, TXD, busy;
  logic [2:0] level;
  logic [7:0] wr_data2  = '0;
  logic       wr_valid2 = 1'b0;
  logic       wr_ready2, TXD2, busy2;
  logic [2:0] level2;

  int tests = 0;
  int failures = 0;
  int cyc = 0;
  int frames_done = 0;
  logic [7:0] exp_q[$];
  int starts[$];

  uart_tx #(.CLK_FREQ_HZ(40), .BAUD_RATE(10), .FIFO_DEPTH(4)) dut (
    .CLK(CLK), .RESET(RESET), .wr_data(wr_data), .wr_valid(wr_valid),
    .wr_ready(wr_ready), .TXD(TXD), .busy(busy), .level(level)
  );

  uart_tx #(.CLK_FREQ_HZ(100), .BAUD_RATE(30), .FIFO_DEPTH(4)) dut3 (
    .CLK(CLK), .RESET(RESET), .wr_data(wr_data2), .wr_valid(wr_valid2),
    .wr_ready(wr_ready2), .TXD(TXD2), .busy(busy2), .level(level2)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
    tests++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Ideal line waveform for one frame, one entry per clock cycle.
  function automatic logic [63:0] frame_bits(input logic [7:0] b, input int div);
    logic [63:0] r;
    int s;
    r = '0;
    for (int k = 0; k < 10 * div; k++) begin
      s = k / div;
      if (s == 0)      r[k] = 1'b0;
      else if (s == 9) r[k] = 1'b1;
      else             r[k] = b[s-1];
    end
    return r;
  endfunction

  task automatic apply_stimulus(input logic [7:0] b, output int acc);
    int n;
    n = 0;
    wr_data  = b;
    wr_valid = 1'b1;
    while (!wr_ready && n < 200) begin
      @(posedge CLK); #1;
      n++;
    end
    if (n >= 200) begin
      tests++;
      failures++;
      $display("[TB] FAIL push_timeout: byte %0h never accepted", b);
    end else begin
      exp_q.push_back(b);
    end
    @(posedge CLK); #1;
    acc = cyc;
  endtask

  task automatic step(input int n);
    repeat (n) begin @(posedge CLK); #1; end
  endtask

  task automatic capture(input bit second, input int n, output logic [63:0] cap, output int busy_hi);
    cap = '0;
    busy_hi = 0;
    for (int k = 0; k < n; k++) begin
      cap[k] = second ? TXD2 : TXD;
      if (second ? busy2 : busy) busy_hi++;
      @(posedge CLK); #1;
    end
  endtask

  task automatic wait_frames(input int target, input int budget);
    int n;
    n = 0;
    while (frames_done < target && n < budget) begin
      @(posedge CLK); #1;
      n++;
    end
    if (frames_done < target) check_output("frame_timeout", frames_done, target);
  endtask

  // Line decoder: every cycle of a frame must hold its bit value; aborted by reset.
  initial begin : monitor
    logic [7:0] got;
    logic bad, aborted;
    int s;
    forever begin
      @(negedge CLK);
      if (!RESET && TXD == 1'b0) begin
        starts.push_back(cyc);
        got = '0;
        bad = 1'b0;
        aborted = 1'b0;
        for (int k = 0; k < 10 * DIV_A; k++) begin
          if (k != 0) begin
            @(negedge CLK);
            if (RESET) begin aborted = 1'b1; break; end
          end
          s = k / DIV_A;
          if (s == 0)                 bad = bad | (TXD != 1'b0);
          else if (s == 9)            bad = bad | (TXD != 1'b1);
          else if (k % DIV_A == 0)    got[s-1] = TXD;
          else                        bad = bad | (TXD != got[s-1]);
        end
        if (!aborted) begin
          check_output("frame_shape", bad, 1'b0);
          if (exp_q.size() == 0) begin
            tests++;
            failures++;
            $display("[TB] FAIL unexpected_frame: got %0h expected none", got);
          end else begin
            check_output("rx_byte", got, exp_q.pop_front());
          end
          frames_done++;
        end
      end
    end
  end

  initial begin : stimulus
    int t, acc, acc11, f0, n0, bh, lows;
    logic [63:0] cap;

    #1 RESET = 1'b1;
    @(posedge CLK); #2;
    check_output("rst_txd", TXD, 1'b1);
    check_output("rst_busy", busy, 1'b0);
    check_output("rst_level", level, 3'd0);
    check_output("rst_ready", wr_ready, 1'b0);
    @(posedge CLK); #1;
    RESET = 1'b0;
    step(2);
    check_output("ready_after_rst", wr_ready, 1'b1);

    // Single byte: exact waveform, busy window and one-cycle level blip.
    apply_stimulus(8'h55, t);
    wr_valid = 1'b0;
    check_output("t1_level_push", level, 3'd1);
    check_output("t1_busy_push", busy, 1'b1);
    step(1);
    check_output("t1_level_pop", level, 3'd0);
    capture(1'b0, 40, cap, bh);
    check_output("t1_wave", cap, frame_bits(8'h55, 4));
    check_output("t1_busy_cycles", bh, 40);
    check_output("t1_txd_idle", TXD, 1'b1);
    check_output("t1_busy_end", busy, 1'b0);
    wait_frames(1, 20);

    // Four back-to-back bytes: frame starts exactly 40 cycles apart.
    step(5);
    n0 = starts.size();
    apply_stimulus(8'h00, acc);
    apply_stimulus(8'hFF, acc);
    apply_stimulus(8'hA5, acc);
    apply_stimulus(8'h01, acc);
    wr_valid = 1'b0;
    wait_frames(5, 300);
    for (int i = 1; i < 4; i++)
      check_output("t2_start_spacing", starts[n0+i] - starts[n0+i-1], 40);
    step(2);
    check_output("t2_busy_end", busy, 1'b0);

    // Six bytes with valid held: FIFO fills, last byte waits for a pop.
    step(5);
    apply_stimulus(8'h11, acc11);
    apply_stimulus(8'h22, acc);
    apply_stimulus(8'h33, acc);
    apply_stimulus(8'h44, acc);
    apply_stimulus(8'h55, acc);
    check_output("t3_level_full", level, 3'd4);
    check_output("t3_ready_full", wr_ready, 1'b0);
    apply_stimulus(8'h66, acc);
    wr_valid = 1'b0;
    check_output("t3_accept_edge", acc - acc11, 42);
    wait_frames(11, 400);
    step(2);

    // Reset during DATA bit 3 of 0xA5 with two bytes still queued.
    step(5);
    apply_stimulus(8'hA5, t);
    apply_stimulus(8'h12, acc);
    apply_stimulus(8'h34, acc);
    wr_valid = 1'b0;
    step(16);
    check_output("t4_level_before", level, 3'd2);
    check_output("t4_txd_bit3", TXD, 1'b0);
    #1 RESET = 1'b1;
    #1;
    check_output("t4_txd_async", TXD, 1'b1);
    check_output("t4_level_async", level, 3'd0);
    check_output("t4_busy_async", busy, 1'b0);
    check_output("t4_ready_async", wr_ready, 1'b0);
    exp_q.delete();
    f0 = frames_done;
    step(2);
    RESET = 1'b0;
    lows = 0;
    for (int k = 0; k < 60; k++) begin
      if (TXD == 1'b0) lows++;
      step(1);
    end
    check_output("t4_no_output", lows, 0);
    check_output("t4_no_frames", frames_done, f0);
    check_output("t4_busy_after", busy, 1'b0);

    // Push lands on the STOP-end pop with one byte queued: level holds at 1.
    apply_stimulus(8'h5A, t);
    wr_valid = 1'b0;
    step(1);
    apply_stimulus(8'hC3, acc);
    wr_valid = 1'b0;
    step(38);
    check_output("t6_level_pre", level, 3'd1);
    apply_stimulus(8'h7E, acc);
    wr_valid = 1'b0;
    check_output("t6_accept_edge", acc - t, 41);
    check_output("t6_level_same", level, 3'd1);
    wait_frames(f0 + 3, 200);

    // DIV=3 instance: every bit three cycles, frame thirty.
    check_output("t5_ready", wr_ready2, 1'b1);
    wr_data2  = 8'h3C;
    wr_valid2 = 1'b1;
    step(1);
    wr_valid2 = 1'b0;
    step(1);
    capture(1'b1, 30, cap, bh);
    check_output("t5_wave", cap, frame_bits(8'h3C, 3));
    check_output("t5_busy_cycles", bh, 30);
    check_output("t5_txd_idle", TXD2, 1'b1);
    check_output("t5_busy_end", busy2, 1'b0);

    step(5);
    check_output("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
